// File: rtl/priv_seq_pkg.sv
// Shared types and constants for the privileged-instruction sequencer.
package priv_seq_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned CSR_AW  = 12;
   localparam int unsigned ZIMM_W  = 5;
   localparam int unsigned CAUSE_W = 4;

   // mcause codes raised by this block
   localparam logic [CAUSE_W-1:0] INSN_FAULT   = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] ILLEGAL_INSN = CAUSE_W'(2);
   localparam logic [CAUSE_W-1:0] BREAKPOINT   = CAUSE_W'(3);
   localparam logic [CAUSE_W-1:0] ECALL_M      = CAUSE_W'(11);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CSR_RD,
      ST_CSR_WR,
      ST_TRAP,
      ST_RET,
      ST_WFI
   } priv_seq_state_t;

   typedef enum logic [1:0] {
      CSR_OP_SWAP,
      CSR_OP_SET,
      CSR_OP_CLR
   } csr_op_t;

   // Operands captured when a CSR instruction is accepted
   typedef struct packed {
      csr_op_t              op;
      logic                 imm;
      logic [ZIMM_W-1:0]    zimm;
      logic [XLEN-1:0]      rs1_data;
      logic                 rs1_x0;
      logic [CSR_AW-1:0]    addr;
   } csr_operands_t;

endpackage

// File: rtl/priv_insn_sequencer_csr_rmw_unit.sv
// Combinational CSR read-modify-write data path: source select plus swap/set/clear.
module csr_rmw_unit
   import priv_seq_pkg::*;
(
   input  csr_op_t             op,
   input  logic                imm,
   input  logic [ZIMM_W-1:0]   zimm,
   input  logic [XLEN-1:0]     rs1_data,
   input  logic [XLEN-1:0]     old_val,
   output logic [XLEN-1:0]     wdata_c
);

   logic [XLEN-1:0] src;

   // Pick the source operand and merge it with the old CSR value
   always_comb begin
      src     = imm ? {{(XLEN-ZIMM_W){1'b0}}, zimm} : rs1_data;
      wdata_c = src;
      case (op)
         CSR_OP_SWAP: wdata_c = src;
         CSR_OP_SET:  wdata_c = old_val | src;
         CSR_OP_CLR:  wdata_c = old_val & ~src;
         default:     wdata_c = src;
      endcase
   end

endmodule

// File: rtl/priv_insn_sequencer.sv
// Sequences privileged instructions: CSR read-modify-write, trap/return requests, wfi.
module priv_insn_sequencer
   import priv_seq_pkg::*;
(
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 insn_valid,
   input  logic                 fault_insn,
   input  logic                 illegal_insn,
   input  logic                 breakpoint,
   input  logic                 ecall_insn,
   input  logic                 ret_insn,
   input  logic                 wfi,
   input  logic                 csr_swap,
   input  logic                 csr_set,
   input  logic                 csr_clr,
   input  logic                 csr_imm,
   input  logic [CSR_AW-1:0]    csr_addr,
   input  logic [ZIMM_W-1:0]    zimm,
   input  logic [XLEN-1:0]      rs1_data,
   input  logic                 rs1_x0,
   input  logic [XLEN-1:0]      pc,
   input  logic                 irq_pending,
   output logic                 stall,
   output logic                 csr_req,
   output logic                 csr_we,
   output logic [CSR_AW-1:0]    csr_addr_o,
   output logic [XLEN-1:0]      csr_wdata,
   input  logic [XLEN-1:0]      csr_rdata,
   input  logic                 csr_ack,
   input  logic                 csr_invalid,
   output logic                 wb_valid,
   output logic [XLEN-1:0]      wb_data,
   output logic                 trap_req,
   output logic [CAUSE_W-1:0]   trap_cause,
   output logic [XLEN-1:0]      trap_epc,
   input  logic                 trap_ack,
   output logic                 ret_req,
   input  logic                 ret_ack
);

   priv_seq_state_t    state_q, state_d;
   csr_operands_t      ops_q, ops_d;
   logic [XLEN-1:0]    old_q, old_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    wb_data_q, wb_data_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               wb_valid_q, wb_valid_d;
   logic               csr_rw_op;
   logic               hit;
   logic [XLEN-1:0]    rmw_wdata;

   // Decode an instruction that needs the sequencer
   assign csr_rw_op = csr_swap | csr_set | csr_clr;
   assign hit       = insn_valid & (fault_insn | illegal_insn | breakpoint | ecall_insn |
                                    ret_insn | wfi | csr_rw_op);

   // Write data is formed from the latched operands and the latched old value
   csr_rmw_unit u_rmw (
      .op       (ops_q.op),
      .imm      (ops_q.imm),
      .zimm     (ops_q.zimm),
      .rs1_data (ops_q.rs1_data),
      .old_val  (old_q),
      .wdata_c  (rmw_wdata)
   );

   // Next-state and next-register values
   always_comb begin
      state_d    = state_q;
      ops_d      = ops_q;
      old_d      = old_q;
      pc_d       = pc_q;
      cause_d    = cause_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hit) begin
               pc_d           = pc;
               ops_d.op       = csr_swap ? CSR_OP_SWAP : (csr_set ? CSR_OP_SET : CSR_OP_CLR);
               ops_d.imm      = csr_imm;
               ops_d.zimm     = zimm;
               ops_d.rs1_data = rs1_data;
               ops_d.rs1_x0   = rs1_x0;
               ops_d.addr     = csr_addr;
               if (fault_insn) begin
                  state_d = ST_TRAP;
                  cause_d = INSN_FAULT;
               end else if (illegal_insn) begin
                  state_d = ST_TRAP;
                  cause_d = ILLEGAL_INSN;
               end else if (breakpoint) begin
                  state_d = ST_TRAP;
                  cause_d = BREAKPOINT;
               end else if (ecall_insn) begin
                  state_d = ST_TRAP;
                  cause_d = ECALL_M;
               end else if (ret_insn) begin
                  state_d = ST_RET;
               end else if (csr_rw_op) begin
                  state_d = ST_CSR_RD;
               end else begin
                  state_d = ST_WFI;
               end
            end
         end

         ST_CSR_RD: begin
            if (csr_ack) begin
               if (csr_invalid) begin
                  state_d = ST_TRAP;
                  cause_d = ILLEGAL_INSN;
               end else begin
                  old_d = csr_rdata;
                  // set/clr with an x0 source only read the CSR
                  if ((ops_q.op == CSR_OP_SWAP) || !ops_q.rs1_x0) begin
                     state_d = ST_CSR_WR;
                  end else begin
                     state_d    = ST_IDLE;
                     wb_valid_d = 1'b1;
                     wb_data_d  = csr_rdata;
                  end
               end
            end
         end

         ST_CSR_WR: begin
            if (csr_ack) begin
               if (csr_invalid) begin
                  state_d = ST_TRAP;
                  cause_d = ILLEGAL_INSN;
               end else begin
                  state_d    = ST_IDLE;
                  wb_valid_d = 1'b1;
                  wb_data_d  = old_q;
               end
            end
         end

         ST_TRAP: begin
            if (trap_ack) state_d = ST_IDLE;
         end

         ST_RET: begin
            if (ret_ack) state_d = ST_IDLE;
         end

         ST_WFI: begin
            if (irq_pending) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q    <= ST_IDLE;
         ops_q      <= '0;
         old_q      <= '0;
         pc_q       <= '0;
         cause_q    <= '0;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ops_q      <= ops_d;
         old_q      <= old_d;
         pc_q       <= pc_d;
         cause_q    <= cause_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
      end
   end

   // Request outputs decoded from the registered state
   assign stall      = (state_q != ST_IDLE) | ((state_q == ST_IDLE) & hit);
   assign csr_req    = (state_q == ST_CSR_RD) | (state_q == ST_CSR_WR);
   assign csr_we     = (state_q == ST_CSR_WR);
   assign csr_addr_o = csr_req ? ops_q.addr : '0;
   assign csr_wdata  = csr_we ? rmw_wdata : '0;
   assign trap_req   = (state_q == ST_TRAP);
   assign ret_req    = (state_q == ST_RET);
   assign trap_cause = cause_q;
   assign trap_epc   = pc_q;
   assign wb_valid   = wb_valid_q;
   assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_priv_insn_sequencer.sv
// Self-checking bench for priv_insn_sequencer: directed scenarios plus randomized traffic.
module tb_priv_insn_sequencer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        insn_valid, fault_insn, illegal_insn, breakpoint, ecall_insn, ret_insn, wfi;
   logic        csr_swap, csr_set, csr_clr, csr_imm, rs1_x0, irq_pending;
   logic [11:0] csr_addr;
   logic [4:0]  zimm;
   logic [31:0] rs1_data, pc, csr_rdata;
   logic        csr_ack, csr_invalid, trap_ack, ret_ack;
   logic        stall, csr_req, csr_we, wb_valid, trap_req, ret_req;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_wdata, wb_data, trap_epc;
   logic [3:0]  trap_cause;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   priv_insn_sequencer dut (
      .CLK(CLK), .nRST(nRST), .insn_valid(insn_valid),
      .fault_insn(fault_insn), .illegal_insn(illegal_insn), .breakpoint(breakpoint),
      .ecall_insn(ecall_insn), .ret_insn(ret_insn), .wfi(wfi),
      .csr_swap(csr_swap), .csr_set(csr_set), .csr_clr(csr_clr), .csr_imm(csr_imm),
      .csr_addr(csr_addr), .zimm(zimm), .rs1_data(rs1_data), .rs1_x0(rs1_x0),
      .pc(pc), .irq_pending(irq_pending), .stall(stall),
      .csr_req(csr_req), .csr_we(csr_we), .csr_addr_o(csr_addr_o), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_ack(csr_ack), .csr_invalid(csr_invalid),
      .wb_valid(wb_valid), .wb_data(wb_data), .trap_req(trap_req), .trap_cause(trap_cause),
      .trap_epc(trap_epc), .trap_ack(trap_ack), .ret_req(ret_req), .ret_ack(ret_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here, outputs sampled 2ns later
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Quiet control inputs, random data on every don't-care bus
   task automatic idle_inputs();
      insn_valid = 0; fault_insn = 0; illegal_insn = 0; breakpoint = 0; ecall_insn = 0;
      ret_insn = 0; wfi = 0; csr_swap = 0; csr_set = 0; csr_clr = 0;
      csr_imm = 1'($urandom); rs1_x0 = 1'($urandom); irq_pending = 0;
      csr_addr = 12'($urandom); zimm = 5'($urandom); rs1_data = $urandom; pc = $urandom;
      csr_rdata = $urandom; csr_ack = 0; csr_invalid = 0; trap_ack = 0; ret_ack = 0;
   endtask

   // Trap is pending this cycle: keep ack low for 'hold' more cycles, then acknowledge
   task automatic finish_trap(input int hold);
      for (int h = 0; h < hold; h++) begin
         step(); idle_inputs(); ret_ack = 1'($urandom); #2;
         chk1("trap_hold_req", trap_req, 1'b1);
         chk1("trap_hold_stall", stall, 1'b1);
      end
      step(); idle_inputs(); trap_ack = 1; #2;
      chk1("trap_ack_cycle_req", trap_req, 1'b1);
      step(); idle_inputs(); #2;
      chk1("trap_done_req", trap_req, 1'b0);
      chk1("trap_done_stall", stall, 1'b0);
      chk1("trap_no_wb", wb_valid, 1'b0);
   endtask

   // One CSR instruction; op 0=swap 1=set 2=clr; dr/dw = ack wait states on read/write
   task automatic run_csr(input int op, input logic imm, input logic [4:0] zi,
                          input logic [31:0] rs1, input logic x0, input logic [11:0] addr,
                          input logic [31:0] old, input logic [31:0] pcv,
                          input int dr, input int dw, input logic inv_rd, input logic inv_wr);
      logic [31:0] src, wexp;
      logic        writes, traps;
      int          rd_ack, wr_ack;
      src = imm ? {27'b0, zi} : rs1;
      if (op == 0)      wexp = src;
      else if (op == 1) wexp = old | src;
      else              wexp = old & ~src;
      writes = !inv_rd && (op == 0 || !x0);
      traps  = inv_rd || (writes && inv_wr);
      rd_ack = 1 + dr;
      wr_ack = writes ? rd_ack + 1 + dw : rd_ack;

      step(); idle_inputs();
      insn_valid = 1; csr_swap = (op == 0); csr_set = (op == 1); csr_clr = (op == 2);
      csr_imm = imm; zimm = zi; rs1_data = rs1; rs1_x0 = x0; csr_addr = addr; pc = pcv;
      #2;
      chk1("csr_accept_stall", stall, 1'b1);
      chk1("csr_accept_noreq", csr_req, 1'b0);
      for (int c = 1; c <= wr_ack; c++) begin
         step(); idle_inputs();
         if ($urandom_range(0, 3) == 0) begin insn_valid = 1; ecall_insn = 1; end
         if (c == rd_ack) begin csr_ack = 1; csr_rdata = old; csr_invalid = inv_rd; end
         if (writes && c == wr_ack) begin csr_ack = 1; csr_invalid = inv_wr; end
         #2;
         chk1("csr_busy_stall", stall, 1'b1);
         chk1("csr_busy_req", csr_req, 1'b1);
         chk1("csr_busy_we", csr_we, 1'(c > rd_ack));
         chk("csr_busy_addr", {20'b0, csr_addr_o}, {20'b0, addr});
         if (c > rd_ack) chk("csr_wdata", csr_wdata, wexp);
         chk1("csr_busy_no_wb", wb_valid, 1'b0);
      end
      step(); idle_inputs(); #2;
      chk1("csr_end_noreq", csr_req, 1'b0);
      if (traps) begin
         chk1("csr_trap_req", trap_req, 1'b1);
         chk("csr_trap_cause", {28'b0, trap_cause}, 32'd2);
         chk("csr_trap_epc", trap_epc, pcv);
         chk1("csr_trap_no_wb", wb_valid, 1'b0);
         finish_trap($urandom_range(0, 2));
      end else begin
         chk1("csr_wb_valid", wb_valid, 1'b1);
         chk("csr_wb_data", wb_data, old);
         chk1("csr_wb_stall", stall, 1'b0);
         step(); idle_inputs(); #2;
         chk1("csr_wb_pulse_end", wb_valid, 1'b0);
      end
   endtask

   // f = {fault, illegal, breakpoint, ecall, ret, wfi}; cs = {swap, set, clr}
   task automatic run_priv(input logic [5:0] f, input logic [2:0] cs, input logic [31:0] pcv,
                           input int hold, input logic irq_early);
      int cause_tbl [4] = '{1, 2, 3, 11};
      int cause = 0;
      for (int i = 0; i < 4; i++)
         if (cause == 0 && f[5-i]) cause = cause_tbl[i];

      step(); idle_inputs();
      insn_valid = 1; {fault_insn, illegal_insn, breakpoint, ecall_insn, ret_insn, wfi} = f;
      {csr_swap, csr_set, csr_clr} = cs; pc = pcv; irq_pending = irq_early;
      #2;
      chk1("priv_accept_stall", stall, 1'b1);

      if (cause != 0) begin
         step(); idle_inputs(); #2;
         chk1("trap_req", trap_req, 1'b1);
         chk("trap_cause", {28'b0, trap_cause}, 32'(cause));
         chk("trap_epc", trap_epc, pcv);
         chk1("trap_no_ret", ret_req, 1'b0);
         chk1("trap_no_csr", csr_req, 1'b0);
         finish_trap(hold);
      end else if (f[1]) begin
         step(); idle_inputs(); #2;
         chk1("ret_req", ret_req, 1'b1);
         chk1("ret_no_trap", trap_req, 1'b0);
         for (int h = 0; h < hold; h++) begin
            step(); idle_inputs(); trap_ack = 1'($urandom); #2;
            chk1("ret_hold_req", ret_req, 1'b1);
            chk1("ret_hold_stall", stall, 1'b1);
         end
         step(); idle_inputs(); ret_ack = 1; #2;
         step(); idle_inputs(); #2;
         chk1("ret_done_req", ret_req, 1'b0);
         chk1("ret_done_stall", stall, 1'b0);
      end else begin
         int wake = irq_early ? 1 : 1 + hold;
         for (int c = 1; c <= wake; c++) begin
            step(); idle_inputs(); irq_pending = (c == wake); #2;
            chk1("wfi_stall", stall, 1'b1);
            chk1("wfi_no_req", csr_req | trap_req | ret_req, 1'b0);
         end
         step(); idle_inputs(); #2;
         chk1("wfi_done_stall", stall, 1'b0);
      end
   endtask

   initial begin
      nRST = 0;
      idle_inputs();
      repeat (3) step();
      nRST = 1;
      #2;
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_csr_req", csr_req, 1'b0);
      chk1("rst_csr_we", csr_we, 1'b0);
      chk("rst_csr_addr_o", {20'b0, csr_addr_o}, 32'd0);
      chk("rst_csr_wdata", csr_wdata, 32'd0);
      chk1("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk1("rst_trap_req", trap_req, 1'b0);
      chk1("rst_ret_req", ret_req, 1'b0);
      chk("rst_trap_cause", {28'b0, trap_cause}, 32'd0);
      chk("rst_trap_epc", trap_epc, 32'd0);

      // csrrs with x0 source, immediate ack: read only
      run_csr(1, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1, 12'h300, 32'h1888, 32'h100, 0, 0, 1'b0, 1'b0);
      // csrrc rs1=0x8, two wait states on each access
      run_csr(2, 1'b0, 5'd0, 32'h8, 1'b0, 12'h300, 32'h1888, 32'h104, 2, 2, 1'b0, 1'b0);
      // best-case swap
      run_csr(0, 1'b0, 5'd0, 32'hCAFE_F00D, 1'b1, 12'h341, 32'h1234_5678, 32'h108, 0, 0, 1'b0, 1'b0);
      // csrrwi to a read-only CSR, rejected on the write
      run_csr(0, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, 12'hF14, 32'h0, 32'h10C, 0, 1, 1'b0, 1'b1);
      // illegal outranks ecall, ack held off 3 cycles
      run_priv(6'b010100, 3'b000, 32'h200, 3, 1'b0);
      // wfi with interrupt already pending
      run_priv(6'b000001, 3'b000, 32'h204, 0, 1'b1);

      // acks with nothing outstanding are ignored
      step(); idle_inputs(); trap_ack = 1; ret_ack = 1; #2;
      step(); idle_inputs(); #2;
      chk1("stray_ack_trap_req", trap_req, 1'b0);
      chk1("stray_ack_ret_req", ret_req, 1'b0);
      chk1("stray_ack_stall", stall, 1'b0);

      // mret interrupted by reset
      step(); idle_inputs(); insn_valid = 1; ret_insn = 1; pc = 32'h300; #2;
      step(); idle_inputs(); #2;
      chk1("mid_ret_req", ret_req, 1'b1);
      step(); idle_inputs(); nRST = 0; #2;
      step(); idle_inputs(); nRST = 1; #2;
      chk1("rst_mid_ret_req", ret_req, 1'b0);
      chk1("rst_mid_ret_stall", stall, 1'b0);
      chk("rst_mid_ret_epc", trap_epc, 32'd0);
      chk("rst_mid_ret_wb_data", wb_data, 32'd0);
      run_csr(0, 1'b0, 5'd0, 32'h55AA_55AA, 1'b0, 12'h340, 32'hA5A5_0000, 32'h304, 1, 0, 1'b0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            run_csr($urandom_range(0, 2), 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                    12'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
         end else begin
            logic [5:0] f;
            logic [2:0] cs;
            f  = 6'($urandom_range(1, 63));
            cs = (f[5:1] != 0) ? 3'($urandom) : 3'b000;
            run_priv(f, cs, $urandom, $urandom_range(0, 3), 1'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
